// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture receiver.
// Optional glitch filter is enabled with PWM_RX_GLITCH_FILTER_EN.
package pwm_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALTO = 2'd1,
    BAJO = 2'd2
  } state_t;

  localparam int DATA_W_DEF     = 29;
  localparam int TIMEOUT_DEF    = 2_000_000;
  localparam int FILTER_LEN_DEF = 4;
endpackage

// File: rtl/pwm_capture_rx_sync_edge_det.sv
// Input synchronizer, optional glitch filter and edge detection.
// Filter compiled in only when PWM_RX_GLITCH_FILTER_EN is defined.
module sync_edge_det
  import pwm_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, s_q;
  logic lvl_d, lvl_q;

  if (FILTER_LEN < 1) begin : g_bad_len
    $error("FILTER_LEN must be at least 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      s_q    <= meta_q;
      lvl_q  <= lvl_d;
    end
  end

`ifdef PWM_RX_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] run_q;

  // run_q counts earlier samples that disagree with the filtered level;
  // the level flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    lvl_d = lvl_q;
    if (s_q != lvl_q && run_q == CW'(FILTER_LEN - 1))
      lvl_d = s_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      run_q <= '0;
    else if (s_q == lvl_q || lvl_d != lvl_q)
      run_q <= '0;
    else
      run_q <= run_q + 1'b1;
  end
`else
  always_comb lvl_d = s_q;
`endif

  assign rise_o = lvl_d & ~lvl_q;
  assign fall_o = ~lvl_d & lvl_q;
endmodule

// File: rtl/pwm_capture_rx.sv
// PWM capture receiver: recovers high time and period per PWM cycle.
// Define PWM_RX_GLITCH_FILTER_EN to enable the input glitch filter.
module pwm_capture_rx
  import pwm_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Sennal_Entrada,
  output logic [DATA_W-1:0] Datos,
  output logic [DATA_W-1:0] Periodo,
  output logic              Dato_Valido,
  output logic              Saturado,
  output logic              Sin_Senal
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic              rise, fall, any_edge, timeout;
  state_t            state_q;
  logic [DATA_W-1:0] hi_q, per_q;
  logic [DATA_W-1:0] hi_d, per_d;
  logic              sat_q;
  logic [IW-1:0]     idle_q;

  sync_edge_det #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_i   (Sennal_Entrada),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign any_edge = rise | fall;
  assign timeout  = !any_edge && idle_q == IW'(TIMEOUT - 1);

  // Saturating increments; hitting all-ones marks the measurement.
  always_comb begin
    hi_d  = (&hi_q)  ? hi_q  : hi_q + 1'b1;
    per_d = (&per_q) ? per_q : per_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      per_q       <= '0;
      sat_q       <= 1'b0;
      idle_q      <= '0;
      Datos       <= '0;
      Periodo     <= '0;
      Dato_Valido <= 1'b0;
      Saturado    <= 1'b0;
      Sin_Senal   <= 1'b1;
    end else begin
      Dato_Valido <= 1'b0;
      if (any_edge)
        idle_q <= '0;
      else if (idle_q != IW'(TIMEOUT - 1))
        idle_q <= idle_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q   <= ALTO;
            hi_q      <= DATA_W'(1);
            per_q     <= DATA_W'(1);
            sat_q     <= 1'b0;
            Sin_Senal <= 1'b0;
          end
        end
        ALTO: begin
          if (timeout) begin
            state_q   <= IDLE;
            Sin_Senal <= 1'b1;
          end else if (fall) begin
            state_q <= BAJO;
            per_q   <= per_d;
            sat_q   <= sat_q | (&per_d);
          end else begin
            hi_q  <= hi_d;
            per_q <= per_d;
            sat_q <= sat_q | (&hi_d) | (&per_d);
          end
        end
        BAJO: begin
          if (timeout) begin
            state_q   <= IDLE;
            Sin_Senal <= 1'b1;
          end else if (rise) begin
            Datos       <= hi_q;
            Periodo     <= per_q;
            Saturado    <= sat_q;
            Dato_Valido <= 1'b1;
            hi_q        <= DATA_W'(1);
            per_q       <= DATA_W'(1);
            sat_q       <= 1'b0;
            state_q     <= ALTO;
          end else begin
            per_q <= per_d;
            sat_q <= sat_q | (&per_d);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_capture_rx.sv
// Directed bench for pwm_capture_rx (29-bit and 8-bit instances).
// Expectations adapt to PWM_RX_GLITCH_FILTER_EN.
module tb_pwm_capture_rx;
  import pwm_pkg::*;

  localparam int FL = 4;
`ifdef PWM_RX_GLITCH_FILTER_EN
  localparam int LAT = 3 + FL - 1;
`else
  localparam int LAT = 3;
`endif
  localparam int TO = 1000;

  logic        clk, rst, sig, sig8;
  logic [28:0] Datos, Periodo;
  logic        Dato_Valido, Saturado, Sin_Senal;
  logic [7:0]  D8, P8;
  logic        DV8, S8, Sin8;

  int checks = 0;
  int errors = 0;
  int nstrobe = 0;
  logic        pre_dv, s_dv, s_sat, s_sin;
  logic [28:0] s_d, s_p;

  pwm_capture_rx #(.DATA_W(29), .TIMEOUT(TO), .FILTER_LEN(FL)) u_dut (
    .clk(clk), .rst(rst), .Sennal_Entrada(sig),
    .Datos(Datos), .Periodo(Periodo), .Dato_Valido(Dato_Valido),
    .Saturado(Saturado), .Sin_Senal(Sin_Senal)
  );

  pwm_capture_rx #(.DATA_W(8), .TIMEOUT(TO), .FILTER_LEN(FL)) u_sat (
    .clk(clk), .rst(rst), .Sennal_Entrada(sig8),
    .Datos(D8), .Periodo(P8), .Dato_Valido(DV8),
    .Saturado(S8), .Sin_Senal(Sin8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (Dato_Valido) nstrobe <= nstrobe + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_period(input int hi, input int lo);
    sig = 1'b1;
    for (int k = 1; k <= hi; k++) begin
      @(negedge clk);
      if (k == LAT - 1) pre_dv = Dato_Valido;
      if (k == LAT) begin
        s_dv = Dato_Valido; s_d = Datos; s_p = Periodo;
        s_sat = Saturado; s_sin = Sin_Senal;
      end
    end
    sig = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sig = 1'b0; sig8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (Datos !== 29'd0) begin errors++; $display("FAIL rst_datos got %0d want 0", Datos); end
    checks++; if (Periodo !== 29'd0) begin errors++; $display("FAIL rst_periodo got %0d want 0", Periodo); end
    checks++; if (Dato_Valido !== 1'b0) begin errors++; $display("FAIL rst_dv got %b want 0", Dato_Valido); end
    checks++; if (Saturado !== 1'b0) begin errors++; $display("FAIL rst_sat got %b want 0", Saturado); end
    checks++; if (Sin_Senal !== 1'b1) begin errors++; $display("FAIL rst_sin got %b want 1", Sin_Senal); end
    checks++; if (u_dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d want 0", u_dut.state_q); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_steady();
    int n0;
    n0 = nstrobe;
    drive_period(100, 300);
    checks++; if (s_dv !== 1'b0) begin errors++; $display("FAIL first_rise_dv got %b want 0", s_dv); end
    for (int p = 2; p <= 10; p++) begin
      drive_period(100, 300);
      checks++; if (pre_dv !== 1'b0) begin errors++; $display("FAIL steady_early p%0d got %b want 0", p, pre_dv); end
      checks++; if (s_dv !== 1'b1) begin errors++; $display("FAIL steady_dv p%0d got %b want 1", p, s_dv); end
      checks++; if (s_d !== 29'd100) begin errors++; $display("FAIL steady_datos p%0d got %0d want 100", p, s_d); end
      checks++; if (s_p !== 29'd400) begin errors++; $display("FAIL steady_periodo p%0d got %0d want 400", p, s_p); end
      checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL steady_sat p%0d got %b want 0", p, s_sat); end
      checks++; if (s_sin !== 1'b0) begin errors++; $display("FAIL steady_sin p%0d got %b want 0", p, s_sin); end
    end
    checks++; if (nstrobe !== n0 + 9) begin errors++; $display("FAIL steady_count got %0d want %0d", nstrobe - n0, 9); end
  endtask

  task automatic test_duty_step();
    drive_period(250, 150);
    checks++; if (s_d !== 29'd100 || s_p !== 29'd400) begin errors++; $display("FAIL step_prev got %0d/%0d want 100/400", s_d, s_p); end
    drive_period(250, 150);
    checks++; if (s_dv !== 1'b1) begin errors++; $display("FAIL step_dv got %b want 1", s_dv); end
    checks++; if (s_d !== 29'd250 || s_p !== 29'd400) begin errors++; $display("FAIL step_new got %0d/%0d want 250/400", s_d, s_p); end
  endtask

  task automatic test_timeout();
    int n0;
    drive_period(100, 300);
    sig = 1'b1;
    repeat (100) @(negedge clk);
    sig = 1'b0;
    n0 = nstrobe;
    for (int k = 1; k <= TO + LAT; k++) begin
      @(negedge clk);
      if (k == TO + LAT - 1) begin
        checks++; if (Sin_Senal !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", Sin_Senal); end
      end
    end
    checks++; if (Sin_Senal !== 1'b1) begin errors++; $display("FAIL to_sin got %b want 1", Sin_Senal); end
    checks++; if (u_dut.state_q !== IDLE) begin errors++; $display("FAIL to_state got %0d want 0", u_dut.state_q); end
    checks++; if (Datos !== 29'd100 || Periodo !== 29'd400) begin errors++; $display("FAIL to_hold got %0d/%0d want 100/400", Datos, Periodo); end
    repeat (2) @(negedge clk);
    checks++; if (nstrobe !== n0) begin errors++; $display("FAIL to_nostrobe got %0d want %0d", nstrobe, n0); end
  endtask

  task automatic test_saturation();
    sig8 = 1'b1;
    repeat (300) @(negedge clk);
    sig8 = 1'b0;
    repeat (100) @(negedge clk);
    sig8 = 1'b1;
    repeat (LAT) @(negedge clk);
    checks++; if (DV8 !== 1'b1) begin errors++; $display("FAIL sat_dv got %b want 1", DV8); end
    checks++; if (D8 !== 8'd255) begin errors++; $display("FAIL sat_datos got %0d want 255", D8); end
    checks++; if (P8 !== 8'd255) begin errors++; $display("FAIL sat_periodo got %0d want 255", P8); end
    checks++; if (S8 !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", S8); end
    checks++; if (Sin8 !== 1'b0) begin errors++; $display("FAIL sat_sin got %b want 0", Sin8); end
    sig8 = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n0;
    drive_period(100, 300);
    sig = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (Datos !== 29'd0 || Periodo !== 29'd0) begin errors++; $display("FAIL mrst_data got %0d/%0d want 0/0", Datos, Periodo); end
    checks++; if (Sin_Senal !== 1'b1) begin errors++; $display("FAIL mrst_sin got %b want 1", Sin_Senal); end
    checks++; if (Dato_Valido !== 1'b0 || Saturado !== 1'b0) begin errors++; $display("FAIL mrst_flags got %b%b want 00", Dato_Valido, Saturado); end
    repeat (2) @(negedge clk);
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = nstrobe;
    repeat (200) @(negedge clk);
    drive_period(100, 300);
    checks++; if (s_dv !== 1'b0) begin errors++; $display("FAIL mrst_first got %b want 0", s_dv); end
    drive_period(100, 300);
    checks++; if (s_dv !== 1'b1 || s_d !== 29'd100 || s_p !== 29'd400) begin errors++; $display("FAIL mrst_meas got %b %0d/%0d want 1 100/400", s_dv, s_d, s_p); end
    checks++; if (nstrobe !== n0 + 1) begin errors++; $display("FAIL mrst_count got %0d want 1", nstrobe - n0); end
  endtask

  task automatic test_glitch();
    int n0, want_n;
    logic [28:0] want_d, want_p;
`ifdef PWM_RX_GLITCH_FILTER_EN
    want_n = 4; want_d = 29'd100; want_p = 29'd400;
`else
    want_n = 7; want_d = 29'd2; want_p = 29'd200;
`endif
    n0 = nstrobe;
    for (int p = 0; p < 3; p++) begin
      sig = 1'b1; repeat (100) @(negedge clk);
      sig = 1'b0; repeat (100) @(negedge clk);
      sig = 1'b1; repeat (2) @(negedge clk);
      sig = 1'b0; repeat (198) @(negedge clk);
    end
    sig = 1'b1;
    repeat (10) @(negedge clk);
    sig = 1'b0;
    checks++; if (nstrobe - n0 !== want_n) begin errors++; $display("FAIL glitch_count got %0d want %0d", nstrobe - n0, want_n); end
    checks++; if (Datos !== want_d || Periodo !== want_p) begin errors++; $display("FAIL glitch_meas got %0d/%0d want %0d/%0d", Datos, Periodo, want_d, want_p); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_step();
    test_timeout();
    test_saturation();
    test_mid_reset();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_capture_rx.md
Name: pwm_capture_rx

Overview:
- Receive-side counterpart of the top-level PWM generator: takes the 1-bit output signal and recovers, once per PWM period, the high time and the period as clock-cycle counts.
- Used in loop-back self-checking: generator `Sennal_Salida` feeds this block's `Sennal_Entrada`, and the recovered `Datos` is compared against the 29-bit word driven into the generator.
- Pure measurement block; it never drives the signal.

Parameters:
- DATA_W, 29: width of the high-time and period counts.
- TIMEOUT, 2_000_000: cycles without any edge before the input is declared dead.
- FILTER_LEN, 4: consecutive equal samples required by the glitch filter (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- Sennal_Entrada  in  1  asynchronous PWM input.
- Datos  out  DATA_W  high-time count of the last complete period.
- Periodo  out  DATA_W  period count (high + low) of the last complete period.
- Dato_Valido  out  1  one-cycle strobe: `Datos`/`Periodo` updated.
- Saturado  out  1  sticky per-measurement: a count hit all-ones in the reported period.
- Sin_Senal  out  1  level: no edge seen for TIMEOUT cycles.

Behaviour:
- Reset values (async assert, sync release): `Datos`=0, `Periodo`=0, `Dato_Valido`=0, `Saturado`=0, `Sin_Senal`=1, FSM=IDLE, counters=0, sync flops=0.
- Input path:
  - 2-flop synchronizer gives `s`.
  - Previous-sample register gives `s_d`.
  - rise = `s` & ~`s_d`; fall = ~`s` & `s_d`.
- FSM states: IDLE, ALTO, BAJO.
  - IDLE: wait for rise, then go to ALTO, cnt_hi=1, cnt_per=1, clear `Sin_Senal`.
  - ALTO:
    - Each cycle cnt_hi++ and cnt_per++.
    - On fall: go to BAJO, cnt_per++ and cnt_hi holds.
  - BAJO:
    - Each cycle cnt_per++.
    - On rise:
      - Latch `Datos`=cnt_hi and `Periodo`=cnt_per (counts exclude the new rising cycle).
      - Pulse `Dato_Valido`, latch `Saturado`.
      - Reload cnt_hi=1, cnt_per=1, go to ALTO.
- Latency: `Dato_Valido` asserts exactly 3 clk cycles after the raw rising edge is sampled (2 sync + 1 edge/latch register). `Datos`/`Periodo` are stable from that cycle until the next strobe.
- First period after IDLE is reported. The rise that leaves IDLE does not strobe.
- Saturation: counters stop at 2^DATA_W-1 and set the internal sat flag. The sat flag is cleared on reload.
- Timeout:
  - Idle counter resets on any edge.
  - On reaching TIMEOUT: `Sin_Senal`=1, FSM goes to IDLE, no strobe, `Datos`/`Periodo` keep their last values.
  - 0% and 100% duty both end here.
- Simultaneous events: rise and fall cannot coincide after the synchronizer. A timeout in the same cycle as an edge is ignored; the edge wins.
- Reset mid-period: measurement discarded, no strobe.

Optional Feature:
- Macro: `PWM_RX_GLITCH_FILTER_EN`.
- Defined:
  - Filtered level after the synchronizer changes only after FILTER_LEN consecutive equal samples of `s`.
  - Pulses shorter than FILTER_LEN cycles are invisible.
  - Latency becomes 3+FILTER_LEN-1 cycles.
  - Measured widths are unchanged, because the delay applies equally to both edges.
- Undefined: `s` is used directly; latency is 3.

Decomposition:
- Shared package `pwm_pkg`:
  - FSM state encoding (IDLE=2'd0, ALTO=2'd1, BAJO=2'd2).
  - DATA_W default 29.
  - TIMEOUT default.
- One sub-module, `sync_edge_det`: synchronizer, optional glitch filter, rise/fall outputs.

Test Plan:
- Stimulus: after rst, 10 periods of high 100 / low 300 cycles. Response: from the 2nd rise on, each strobe shows `Datos`=100, `Periodo`=400, `Saturado`=0, `Sin_Senal`=0; strobes 400 cycles apart, 3 cycles after each rise.
- Stimulus: duty step 100/400 to 250/400 mid-stream. Response: the first strobe after the step shows 250/400, with no intermediate value.
- Stimulus: input held 0 after activity (TIMEOUT=1000 in bench). Response: `Sin_Senal`=1 exactly 1000 cycles after the last edge, FSM=IDLE, `Datos` holds 100.
- Stimulus: DATA_W=8, high 300 / low 100. Response: `Datos`=255, `Periodo`=255, `Saturado`=1.
- Stimulus: rst asserted for 5 cycles mid-high phase. Response: outputs return to reset values asynchronously. Next strobe comes only after a full new period, with correct counts.
- Stimulus: with `PWM_RX_GLITCH_FILTER_EN`, FILTER_LEN=4, 2-cycle spikes injected into the low phase. Response: `Datos`/`Periodo` unchanged, no extra strobes. Without the macro: spurious strobes appear.
